// File: rtl/sram_controller_if.sv
// MEM-stage request bus for sram_controller.
//   wr_en/rd_en   : request strobes, held by the master until ready
//   address       : byte address of the request
//   write_data    : 32-bit store data
//   read_data     : 32-bit load result (registered in the controller)
//   ready         : high when the pipeline may advance
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output wr_en, rd_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  wr_en, rd_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/sram_controller.sv
// 32-bit word access onto a 16-bit asynchronous SRAM as two half-word
// accesses (low half first), followed by an optional settle period.
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   bus        : MEM-stage request bus (slave side)
//   SRAM_DQ    : bidirectional SRAM data, driven only during write halves
//   SRAM_ADDR  : half-word address {word_index, half}
//   SRAM_*_N   : chip controls; only SRAM_WE_N toggles
module sram_controller #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  sram_controller_if.slave    bus,
  inout  wire  [15:0]         SRAM_DQ,
  output logic [17:0]         SRAM_ADDR,
  output logic                SRAM_UB_N,
  output logic                SRAM_LB_N,
  output logic                SRAM_CE_N,
  output logic                SRAM_OE_N,
  output logic                SRAM_WE_N
);

  localparam int unsigned IDX_W  = 17;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned HALF_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACC_LO = 3'd1,
    ACC_HI = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   addr_q;
  logic [WORD_W-1:0]   wdata_q;
  logic                op_wr_q;
  logic [CNT_W-1:0]    wait_q;
  logic [WORD_W-1:0]   rdata_q;
  logic [IDX_W-1:0]    word_idx;
  logic                req;
  logic                rdy;
  logic                dq_oe;
  logic [HALF_W-1:0]   dq_out;

  assign req      = bus.wr_en || bus.rd_en;
  // Out-of-window addresses simply wrap within the 2^17-word array.
  assign word_idx = IDX_W'((addr_q - WORD_W'(BASE_ADDR)) >> 2);

  assign SRAM_UB_N     = 1'b0;
  assign SRAM_LB_N     = 1'b0;
  assign SRAM_CE_N     = 1'b0;
  assign SRAM_OE_N     = 1'b0;
  assign SRAM_DQ       = dq_oe ? dq_out : {HALF_W{1'bz}};
  assign bus.read_data = rdata_q;
  assign bus.ready     = rdy;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (req) state_d = ACC_LO;
      ACC_LO: state_d = ACC_HI;
      ACC_HI: state_d = (WAIT_CYCLES > 0) ? WAIT : DONE;
      WAIT:   if (wait_q <= CNT_W'(1)) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: address half select, write strobe/drive, ready.
  always_comb begin
    SRAM_ADDR = {word_idx, 1'b0};
    SRAM_WE_N = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = wdata_q[HALF_W-1:0];
    rdy       = 1'b0;
    case (state_q)
      IDLE: rdy = !req;
      ACC_LO: begin
        if (op_wr_q) begin
          SRAM_WE_N = 1'b0;
          dq_oe     = 1'b1;
        end
      end
      ACC_HI: begin
        SRAM_ADDR = {word_idx, 1'b1};
        dq_out    = wdata_q[WORD_W-1:HALF_W];
        if (op_wr_q) begin
          SRAM_WE_N = 1'b0;
          dq_oe     = 1'b1;
        end
      end
      DONE: rdy = 1'b1;
      default: ;
    endcase
  end

  // Request latch, settle counter and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      op_wr_q <= 1'b0;
      wait_q  <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            addr_q  <= bus.address;
            wdata_q <= bus.write_data;
            op_wr_q <= bus.wr_en;  // write wins when both are asserted
          end
        end
        ACC_LO: begin
          if (!op_wr_q) rdata_q[HALF_W-1:0] <= SRAM_DQ;
        end
        ACC_HI: begin
          if (!op_wr_q) rdata_q[WORD_W-1:HALF_W] <= SRAM_DQ;
          wait_q <= CNT_W'(WAIT_CYCLES);
        end
        WAIT: wait_q <= wait_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: two instances (default settle and
// zero settle), each with a behavioural async SRAM on its pins.
module tb_sram_controller;

  logic clk = 1'b0;
  logic rst0, rst1;
  always #5 clk = ~clk;

  sram_controller_if b0();
  sram_controller_if b1();

  wire  [15:0] dq0, dq1;
  logic [17:0] addr0, addr1;
  logic ub0, lb0, ce0, oe0, we0;
  logic ub1, lb1, ce1, oe1, we1;

  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst0), .bus(b0), .SRAM_DQ(dq0), .SRAM_ADDR(addr0),
    .SRAM_UB_N(ub0), .SRAM_LB_N(lb0), .SRAM_CE_N(ce0), .SRAM_OE_N(oe0),
    .SRAM_WE_N(we0));

  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst1), .bus(b1), .SRAM_DQ(dq1), .SRAM_ADDR(addr1),
    .SRAM_UB_N(ub1), .SRAM_LB_N(lb1), .SRAM_CE_N(ce1), .SRAM_OE_N(oe1),
    .SRAM_WE_N(we1));

  // Behavioural SRAMs: drive DQ whenever not being written.
  logic [15:0] mem0 [0:1023];
  logic [15:0] mem1 [0:1023];
  assign dq0 = we0 ? mem0[addr0[9:0]] : 16'bz;
  assign dq1 = we1 ? mem1[addr1[9:0]] : 16'bz;
  always @(posedge clk) if (!we0) mem0[addr0[9:0]] <= dq0;
  always @(posedge clk) if (!we1) mem1[addr1[9:0]] <= dq1;

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] refw [int];
  logic [31:0] last_rd [2];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int inst, input bit wr, input bit rd,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (inst == 0) begin
      b0.wr_en = wr; b0.rd_en = rd; b0.address = addr; b0.write_data = wdata;
    end else begin
      b1.wr_en = wr; b1.rd_en = rd; b1.address = addr; b1.write_data = wdata;
    end
  endtask

  function automatic logic get_ready(input int inst);
    return (inst == 0) ? b0.ready : b1.ready;
  endfunction

  function automatic logic [31:0] get_rd(input int inst);
    return (inst == 0) ? b0.read_data : b1.read_data;
  endfunction

  function automatic logic get_we(input int inst);
    return (inst == 0) ? we0 : we1;
  endfunction

  // One access: push expectation, hold request until ready, pop and compare.
  // Returns one cycle after ready, at the start of the next IDLE cycle.
  task automatic access(input int inst, input string tag, input bit wr, input bit rd,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input bit perturb);
    exp_t e;
    int   c;
    bit   done;
    bit   we_low;
    int   key;
    key = inst * (1 << 17) + int'(17'((addr - 32'd1024) >> 2));
    if (wr) begin
      refw[key] = wdata;
      e.data = last_rd[inst];
    end else begin
      e.data = refw.exists(key) ? refw[key] : 32'hxxxxxxxx;
      last_rd[inst] = e.data;
    end
    e.lat = 3 + ((inst == 0) ? 2 : 0);
    sb.push_back(e);
    drive(inst, wr, rd, addr, wdata);
    c = 0; done = 1'b0; we_low = 1'b0;
    while (!done && c < 40) begin
      @(negedge clk);
      if (get_we(inst) === 1'b0) we_low = 1'b1;
      if (get_ready(inst) === 1'b1) done = 1'b1;
      else begin
        @(posedge clk); #1;
        c++;
        if (perturb && c == 2) drive(inst, wr, rd, addr ^ 32'h40, ~wdata);
      end
    end
    e = sb.pop_front();
    check({tag, " ready"}, 32'(done), 32'd1);
    check({tag, " latency"}, 32'(c), 32'(e.lat));
    check({tag, " read_data"}, get_rd(inst), e.data);
    if (!wr) check({tag, " we_n quiet"}, 32'(we_low), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem0[i] = 16'h0;
      mem1[i] = 16'h0;
    end
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    rst0 = 1'b1; rst1 = 1'b1;
    drive(0, 0, 0, 32'h0, 32'h0);
    drive(1, 0, 0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1; rst0 = 1'b0; rst1 = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst ready", 32'(b0.ready), 32'd1);
    check("rst read_data", b0.read_data, 32'h0);
    check("rst we_n", 32'(we0), 32'd1);
    check("rst sram_addr", 32'(addr0), 32'h3FE00);
    check("rst ctl_n", {28'h0, ub0, lb0, ce0, oe0}, 32'h0);
    @(posedge clk); #1;

    // Basic write then read
    access(0, "wr1024", 1, 0, 32'd1024, 32'hDEADBEEF, 0);
    check("w0 lo", 32'(mem0[0]), 32'h0000BEEF);
    check("w0 hi", 32'(mem0[1]), 32'h0000DEAD);
    access(0, "rd1024", 0, 1, 32'd1024, 32'h0, 0);

    // Back-to-back write/read/read
    access(0, "wr1028", 1, 0, 32'd1028, 32'h12345678, 0);
    access(0, "rd1028", 0, 1, 32'd1028, 32'h0, 0);
    access(0, "rd1024b", 0, 1, 32'd1024, 32'h0, 0);
    check("w1 lo", 32'(mem0[2]), 32'h00005678);
    check("w1 hi", 32'(mem0[3]), 32'h00001234);

    // Both strobes high is a write; mid-access input changes are ignored
    access(0, "wrrd1032", 1, 1, 32'd1032, 32'hCAFEF00D, 1);
    check("w2 lo", 32'(mem0[4]), 32'h0000F00D);
    check("w2 hi", 32'(mem0[5]), 32'h0000CAFE);
    check("perturb untouched lo", 32'(mem0[36]), 32'h0);
    check("perturb untouched hi", 32'(mem0[37]), 32'h0);
    drive(0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    check("idle ready", 32'(b0.ready), 32'd1);
    @(posedge clk); #1;

    // Reset asserted while in ACC_HI of a read
    drive(0, 0, 1, 32'd1024, 32'h0);
    @(negedge clk);
    check("pre-rst ready", 32'(b0.ready), 32'd0);
    @(posedge clk); #1;            // ACC_LO
    @(posedge clk); #1;            // ACC_HI
    rst0 = 1'b1;
    @(posedge clk); #1;
    rst0 = 1'b0;
    drive(0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    check("abort read_data", b0.read_data, 32'h0);
    check("abort ready", 32'(b0.ready), 32'd1);
    check("abort we_n", 32'(we0), 32'd1);
    last_rd[0] = 32'h0;
    @(posedge clk); #1;
    access(0, "rd_after_rst", 0, 1, 32'd1024, 32'h0, 0);

    // Zero settle-cycle instance
    access(1, "z_wr1024", 1, 0, 32'd1024, 32'hDEADBEEF, 0);
    check("z w0 lo", 32'(mem1[0]), 32'h0000BEEF);
    check("z w0 hi", 32'(mem1[1]), 32'h0000DEAD);
    access(1, "z_rd1024", 0, 1, 32'd1024, 32'h0, 0);
    drive(1, 0, 0, 32'h0, 32'h0);

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
